// File: rtl/countid_action.sv
// countid_action: maps a matched rule index (countid) to a configurable action word.
// A one-cycle table read stage feeds a small output FIFO with valid/ready on the
// consumer side. The upstream side has no backpressure, so lookups that find the
// FIFO full (with no pop in the same cycle) are dropped and counted.
module countid_action #(
    parameter int width_count  = 6,
    parameter int width_action = 32,
    parameter int fifo_depth   = 4,
    parameter int width_drop   = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            countid_valid,
    input  logic [width_count-1:0]          countid,
    input  logic                            cfg_wr,
    input  logic [width_count-1:0]          cfg_addr,
    input  logic [width_action-1:0]         cfg_data,
    output logic                            action_valid,
    input  logic                            action_ready,
    output logic [width_count-1:0]          action_countid,
    output logic [width_action-1:0]         action,
    output logic [$clog2(fifo_depth):0]     fifo_count,
    output logic [width_drop-1:0]           drop_count
);

    localparam int ENTRIES = 1 << width_count;
    localparam int AW      = $clog2(fifo_depth);
    localparam int CW      = AW + 1;

    logic [width_action-1:0] table_q [ENTRIES];

    logic                    rd_valid_q;
    logic [width_count-1:0]  rd_countid_q;
    logic [width_action-1:0] rd_data_q;

    logic [width_count-1:0]  mem_id_q   [fifo_depth];
    logic [width_action-1:0] mem_data_q [fifo_depth];

    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic [width_drop-1:0]   drop_q, drop_d;

    logic                    full;
    logic                    pop;
    logic                    push;
    logic                    drop;

    // Action table: cleared on reset, written by the configuration port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '0;
            end
        end else if (cfg_wr) begin
            table_q[cfg_addr] <= cfg_data;
        end
    end

    // Lookup stage: the read sees the table before any same-cycle write lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid_q   <= 1'b0;
            rd_countid_q <= '0;
            rd_data_q    <= '0;
        end else begin
            rd_valid_q <= countid_valid;
            if (countid_valid) begin
                rd_countid_q <= countid;
                rd_data_q    <= table_q[countid];
            end
        end
    end

    // FIFO control: a full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        pop      = action_valid && action_ready;
        full     = (count_q == CW'(fifo_depth));
        push     = rd_valid_q && (!full || pop);
        drop     = rd_valid_q && full && !pop;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        drop_d = drop_q;
        if (drop && (drop_q != {width_drop{1'b1}})) begin
            drop_d = drop_q + width_drop'(1);
        end
    end

    // FIFO pointers, occupancy and saturating drop counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // FIFO storage; contents need no reset because the outputs are gated by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_id_q[wr_ptr_q]   <= rd_countid_q;
            mem_data_q[wr_ptr_q] <= rd_data_q;
        end
    end

    // Present the head entry, forced to zero while the FIFO is empty.
    always_comb begin
        action_valid   = (count_q != '0);
        action_countid = action_valid ? mem_id_q[rd_ptr_q]   : '0;
        action         = action_valid ? mem_data_q[rd_ptr_q] : '0;
        fifo_count     = count_q;
        drop_count     = drop_q;
    end

endmodule
